// File: rtl/fifo_stream_serializer.sv
`default_nettype none
// ============================================================================
// fifo_stream_serializer: drains a FIFO read port and emits each word as
// DATA_WIDTH/OUT_WIDTH slices on a valid/ready stream.  Revision: 1.0
// ============================================================================
module fifo_stream_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int FWFT       = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int c_RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int c_CW    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_RATIO - 1);

    if (((DATA_WIDTH % OUT_WIDTH) != 0) || (c_RATIO < 2)) begin : g_bad_ratio
        $error("fifo_stream_serializer: DATA_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [c_CW-1:0]                      r_cnt;
    logic [c_CW-1:0]                      w_cnt_nxt;
    logic [DATA_WIDTH-1:0]                r_word;
    logic [DATA_WIDTH-1:0]                w_word_nxt;
    logic [c_RATIO-1:0][OUT_WIDTH-1:0]    w_slices;
    logic [c_CW-1:0]                      w_idx;
    logic                                 w_at_last;

    assign w_slices  = r_word;
    assign w_idx     = (MSB_FIRST != 0) ? (c_LAST - r_cnt) : r_cnt;
    assign w_at_last = (r_cnt == c_LAST);
    assign busy_o    = (r_state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        fifo_rd_o   = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = '0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    fifo_rd_o = 1'b1;
                    if (FWFT != 0) begin
                        w_word_nxt  = fifo_data_i;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_word_nxt  = fifo_data_i;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                out_valid_o = 1'b1;
                out_data_o  = w_slices[w_idx];
                out_last_o  = w_at_last;
                if (out_ready_i) begin
                    if (!w_at_last) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else if (!fifo_empty_i) begin
                        // Refill on the last transfer so FWFT streams without a bubble
                        fifo_rd_o = 1'b1;
                        if (FWFT != 0) begin
                            w_word_nxt = fifo_data_i;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
